// File: rtl/agc_monitor_sequencer_if.sv
// Host command channel for the AGC monitor sequencer.
//   cmd_valid / cmd_ready : command handshake (accept on both high)
//   cmd_op                : 0=START 1=STOP 2=RUN 3=LOAD
//   cmd_data              : LOAD word, bit0 -> MDT01
//   done / err            : one-cycle completion pulse with status (0=ok 1=timeout 2=gojam)
interface agc_monitor_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        done;
    logic [1:0]  err;

    // Host side issues commands and observes completion.
    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, done, err
    );

    // Sequencer side accepts commands and reports completion.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, done, err
    );
endinterface

// File: rtl/agc_monitor_sequencer.sv
// Ground-support monitor driver for the AGC test connector.
// Turns host commands into MSTRT/MSTP/MLOAD/MDT drives aligned to the AGC
// timepulse train, with inter-pulse timeout and GOJAM abort.
//   SIM_CLK, SIM_RST_n : clock, async active-low reset
//   MT[11:0]           : timepulses MT12..MT01 (bit 0 = MT01), one-hot or zero
//   MGOJAM             : AGC restart indication
//   host               : command channel (slave modport)
//   MSTRT, MSTP, MLOAD : monitor start pulse, stop level, load strobe
//   MDT[15:0]          : monitor data lines MDT16..MDT01
module agc_monitor_sequencer #(
    parameter int unsigned PULSE_LEN = 32,
    parameter int unsigned STOP_MCT  = 2,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                    SIM_CLK,
    input  logic                    SIM_RST_n,
    input  logic [11:0]             MT,
    input  logic                    MGOJAM,
    agc_monitor_sequencer_if.slave  host,
    output logic                    MSTRT,
    output logic                    MSTP,
    output logic                    MLOAD,
    output logic [15:0]             MDT
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned MT_W   = 12;
    localparam int unsigned MT01   = 0;
    localparam int unsigned MT12   = 11;

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_STOP   = 2'd1;
    localparam logic [1:0] OP_RUN    = 2'd2;
    localparam logic [1:0] OP_LOAD   = 2'd3;
    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_TMO   = 2'd1;
    localparam logic [1:0] ERR_GOJAM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_START_P, S_STOP_W, S_RUN_W, S_LOAD_A, S_LOAD_H, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]    tmo_inc;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MT_W-1:0]     mt_q;
    logic [MT_W-1:0]     mt_rise;
    logic                mstrt_q, mstrt_d;
    logic                mstp_q, mstp_d;
    logic                mload_q, mload_d;
    logic [DATA_W-1:0]   mdt_q, mdt_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic                waiting;
    logic                complete;

    // Timepulse rising edges; every sequencing decision keys off these.
    assign mt_rise = MT & ~mt_q;

    // Quiet-time counter: any timepulse edge restarts the window.
    assign tmo_inc = (|mt_rise) ? '0 : tmo_cnt_q + CNT_W'(1);

    assign host.cmd_ready = (state_q == S_IDLE);
    assign host.done      = done_q;
    assign host.err       = err_q;
    assign MSTRT          = mstrt_q;
    assign MSTP           = mstp_q;
    assign MLOAD          = mload_q;
    assign MDT            = mdt_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        evt_cnt_d = evt_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        data_d    = data_q;
        mstrt_d   = mstrt_q;
        mstp_d    = mstp_q;
        mload_d   = mload_q;
        mdt_d     = mdt_q;
        done_d    = 1'b0;
        err_d     = ERR_OK;
        waiting   = 1'b0;
        complete  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    data_d    = host.cmd_data;
                    evt_cnt_d = '0;
                    tmo_cnt_d = '0;
                    case (host.cmd_op)
                        OP_START: begin
                            state_d = S_START_P;
                            mstrt_d = 1'b1;
                        end
                        OP_STOP: begin
                            state_d = S_STOP_W;
                            mstp_d  = 1'b1;
                        end
                        OP_RUN: begin
                            state_d = S_RUN_W;
                            mstp_d  = 1'b0;
                        end
                        OP_LOAD: state_d = S_LOAD_A;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            // START provokes GOJAM itself, so only the pulse length matters here.
            S_START_P: begin
                if (evt_cnt_q == CNT_W'(PULSE_LEN - 1)) begin
                    mstrt_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    evt_cnt_d = evt_cnt_q + CNT_W'(1);
                end
            end
            S_STOP_W: begin
                waiting = 1'b1;
                if (mt_rise[MT12]) begin
                    if (evt_cnt_q == CNT_W'(STOP_MCT - 1)) begin
                        complete = 1'b1;
                    end else begin
                        evt_cnt_d = evt_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RUN_W: begin
                waiting  = 1'b1;
                complete = mt_rise[MT12];
            end
            // Raise the load window on MT01 so the AGC sees a full MCT.
            S_LOAD_A: begin
                waiting = 1'b1;
                if (mt_rise[MT01]) begin
                    mdt_d   = data_q;
                    mload_d = 1'b1;
                    state_d = S_LOAD_H;
                end
            end
            S_LOAD_H: begin
                waiting  = 1'b1;
                complete = mt_rise[MT01];
            end
            // Completion cycle: cmd_ready stays low so a strobe here is dropped.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Shared termination for MT-paced states: GOJAM > completion > timeout.
        if (waiting) begin
            tmo_cnt_d = tmo_inc;
            if (MGOJAM || complete || (tmo_inc == CNT_W'(TIMEOUT))) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                mload_d = 1'b0;
                mdt_d   = '0;
                if (MGOJAM) begin
                    err_d = ERR_GOJAM;
                end else if (complete) begin
                    err_d = ERR_OK;
                end else begin
                    err_d = ERR_TMO;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state_q   <= S_IDLE;
            evt_cnt_q <= '0;
            tmo_cnt_q <= '0;
            data_q    <= '0;
            mt_q      <= '0;
            mstrt_q   <= 1'b0;
            mstp_q    <= 1'b0;
            mload_q   <= 1'b0;
            mdt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            evt_cnt_q <= evt_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            data_q    <= data_d;
            mt_q      <= MT;
            mstrt_q   <= mstrt_d;
            mstp_q    <= mstp_d;
            mload_q   <= mload_d;
            mdt_q     <= mdt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_agc_monitor_sequencer.sv
// Bench for agc_monitor_sequencer: random timepulse trains, GOJAM pulses and
// busy-time command noise, checked against a transaction-level model that
// scans the planned stimulus for the event that ends each command.
module tb_agc_monitor_sequencer;

    localparam int PULSE_LEN = 32;
    localparam int STOP_MCT  = 2;
    localparam int TIMEOUT   = 4096;
    localparam int PLAN_N    = 4400;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_LOAD  = 2'd3;

    logic        sim_clk = 1'b0;
    logic        sim_rst_n;
    logic [11:0] mt;
    logic        mgojam;
    logic        mstrt, mstp, mload;
    logic [15:0] mdt;

    agc_monitor_sequencer_if host();

    agc_monitor_sequencer #(
        .PULSE_LEN (PULSE_LEN),
        .STOP_MCT  (STOP_MCT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .SIM_CLK   (sim_clk),
        .SIM_RST_n (sim_rst_n),
        .MT        (mt),
        .MGOJAM    (mgojam),
        .host      (host),
        .MSTRT     (mstrt),
        .MSTP      (mstp),
        .MLOAD     (mload),
        .MDT       (mdt)
    );

    always #5 sim_clk = ~sim_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cmd = 0;
    logic [11:0] mt_plan [PLAN_N];
    logic        gj_plan [PLAN_N];
    logic [11:0] mt_prev;
    logic        mstp_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_mstrt, input logic e_mstp,
                              input logic e_mload, input logic [15:0] e_mdt, input logic e_done,
                              input logic [1:0] e_err, input logic e_ready);
        check_eq({tag, " MSTRT"},     32'(mstrt),          32'(e_mstrt));
        check_eq({tag, " MSTP"},      32'(mstp),           32'(e_mstp));
        check_eq({tag, " MLOAD"},     32'(mload),          32'(e_mload));
        check_eq({tag, " MDT"},       32'(mdt),            32'(e_mdt));
        check_eq({tag, " done"},      32'(host.done),      32'(e_done));
        check_eq({tag, " err"},       32'(host.err),       32'(e_err));
        check_eq({tag, " cmd_ready"}, 32'(host.cmd_ready), 32'(e_ready));
    endtask

    function automatic logic [11:0] mt_at(input int i);
        if (i < 0)       return mt_prev;
        if (i >= PLAN_N) return 12'd0;
        return mt_plan[i];
    endfunction

    // Stimulus plan: mode 0 normal MCT train, 1 MT frozen at 0, 2 freeze later,
    // 3 random GOJAM pulse, 4 GOJAM three cycles after the first MT01 edge.
    task automatic build_plan(input int mode);
        int          i, k, h, g, f;
        logic [11:0] one;
        one = 12'd1;
        i = 0;
        k = int'($urandom_range(0, 11));
        while (i < PLAN_N) begin
            h = int'($urandom_range(1, 3));
            for (int j = 0; j < h && i < PLAN_N; j++) begin mt_plan[i] = one << k; i++; end
            g = int'($urandom_range(0, 1));
            for (int j = 0; j < g && i < PLAN_N; j++) begin mt_plan[i] = 12'd0; i++; end
            k = (k == 11) ? 0 : k + 1;
        end
        for (int j = 0; j < PLAN_N; j++) gj_plan[j] = 1'b0;
        case (mode)
            1: for (int j = 0; j < PLAN_N; j++) mt_plan[j] = 12'd0;
            2: begin
                f = int'($urandom_range(5, 80));
                for (int j = f; j < PLAN_N; j++) mt_plan[j] = 12'd0;
            end
            3: gj_plan[int'($urandom_range(1, 40))] = 1'b1;
            4: begin
                for (int j = 1; j < 200; j++) begin
                    if (mt_plan[j][0] && !mt_plan[j-1][0]) begin
                        gj_plan[j+3] = 1'b1;
                        break;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One command: plan stimulus, predict the ending edge, then run and compare.
    // Edge e is the e-th rising clock after the accept cycle's inputs are driven.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] data, input int mode);
        int          d, l, mct, quiet;
        logic [1:0]  eerr;
        logic [11:0] rises;
        string       tag;
        mt_prev = mt;
        build_plan(mode);
        d = 0; l = 0; mct = 0; quiet = 0; eerr = 2'd0;
        if (op == OP_START) begin
            d = PULSE_LEN + 1;
        end else begin
            for (int e = 2; e < PLAN_N - 2 && d == 0; e++) begin
                rises = mt_at(e - 1) & ~mt_at(e - 2);
                if (gj_plan[e - 1]) begin
                    d = e; eerr = 2'd2;
                end else if (op == OP_STOP && rises[11] && mct + 1 == STOP_MCT) begin
                    d = e;
                end else if (op == OP_RUN && rises[11]) begin
                    d = e;
                end else if (op == OP_LOAD && rises[0] && l != 0) begin
                    d = e;
                end else begin
                    if (op == OP_STOP && rises[11]) mct++;
                    if (op == OP_LOAD && rises[0]) l = e;
                    quiet = (rises != 12'd0) ? 0 : quiet + 1;
                    if (quiet == TIMEOUT) begin d = e; eerr = 2'd1; end
                end
            end
            if (d == 0) d = PLAN_N - 3;
        end
        if (op == OP_STOP) mstp_exp = 1'b1;
        else if (op == OP_RUN) mstp_exp = 1'b0;

        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_data  = data;
        mt             = mt_plan[0];
        mgojam         = gj_plan[0];
        for (int e = 1; e <= d + 1; e++) begin
            @(posedge sim_clk); #1;
            tag = $sformatf("cmd%0d op%0d e%0d", n_cmd, op, e);
            check_outs(tag,
                       (op == OP_START) && (e <= PULSE_LEN),
                       mstp_exp,
                       (op == OP_LOAD) && (l != 0) && (e >= l) && (e < d),
                       ((op == OP_LOAD) && (l != 0) && (e >= l) && (e < d)) ? data : 16'd0,
                       e == d,
                       (e == d) ? eerr : 2'd0,
                       e == d + 1);
            mt             = mt_plan[e];
            mgojam         = gj_plan[e];
            host.cmd_valid = (e <= d) ? 1'($urandom_range(0, 1)) : 1'b0;
            host.cmd_op    = 2'($urandom);
            host.cmd_data  = 16'($urandom);
        end
        @(posedge sim_clk); #1;
        check_outs($sformatf("cmd%0d idle", n_cmd), 1'b0, mstp_exp, 1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
        n_cmd++;
    endtask

    initial begin
        int n_tmo;
        int r, mode;
        logic [1:0] op;
        sim_rst_n      = 1'b0;
        mt             = 12'd0;
        mgojam         = 1'b0;
        host.cmd_valid = 1'b0;
        host.cmd_op    = 2'd0;
        host.cmd_data  = 16'd0;
        mstp_exp       = 1'b0;

        // Reset held with MT toggling, then idle after release.
        for (int i = 0; i < 6; i++) begin
            @(posedge sim_clk); #1;
            check_outs($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
            mt = 12'($urandom);
        end
        sim_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge sim_clk); #1;
            check_outs($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
            mt = 12'($urandom);
        end

        // Directed scenarios.
        run_cmd(OP_START, 16'd0, 3);
        run_cmd(OP_LOAD, 16'o52525, 0);
        run_cmd(OP_STOP, 16'd0, 0);
        run_cmd(OP_RUN, 16'd0, 0);
        run_cmd(OP_STOP, 16'd0, 0);
        run_cmd(OP_LOAD, 16'h1234, 1);
        run_cmd(OP_LOAD, 16'hBEEF, 4);

        // Reset in the middle of a STOP drops drives with no done.
        host.cmd_valid = 1'b1;
        host.cmd_op    = OP_STOP;
        @(posedge sim_clk); #1;
        host.cmd_valid = 1'b0;
        check_eq("midrst MSTP set", 32'(mstp), 32'(1));
        repeat (3) @(posedge sim_clk);
        #2 sim_rst_n = 1'b0;
        #1 check_outs("midrst async", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
        @(posedge sim_clk); #1;
        sim_rst_n = 1'b1;
        mstp_exp  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sim_clk); #1;
            check_outs($sformatf("midrst%0d", i), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd0, 1'b1);
        end

        // Randomized commands.
        n_tmo = 0;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom);
            r  = int'($urandom_range(0, 9));
            if (r == 0 && n_tmo < 4) begin
                mode = int'($urandom_range(1, 2));
                n_tmo++;
            end else if (r == 1 || r == 2) begin
                mode = (op == OP_LOAD && r == 2) ? 4 : 3;
            end else begin
                mode = 0;
            end
            run_cmd(op, 16'($urandom), mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
